// File: rtl/layer_router_pkg.sv
// Shared constants for layer_stream_router: APB register map, layer select
// codes, FSM states and STATUS bit positions.
package layer_router_pkg;

    localparam logic [31:0] ADDR_CTRL      = 32'h00;
    localparam logic [31:0] ADDR_STATUS    = 32'h04;
    localparam logic [31:0] ADDR_IN_CNT    = 32'h08;
    localparam logic [31:0] ADDR_OUT_CNT   = 32'h0C;
    localparam logic [31:0] ADDR_STALL_CNT = 32'h10;

    localparam logic [1:0] SEL_FC      = 2'd0;
    localparam logic [1:0] SEL_CONV    = 2'd1;
    localparam logic [1:0] SEL_POOL    = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

    localparam int CTRL_START_BIT = 4;
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_ERR     = 1;
    localparam int STATUS_DONE    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_e;

    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        return 3'b001 << sel;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry AXI-Stream skid buffer. Upstream ready comes only from the
// registered occupancy, so no combinational path from m_ready_i to s_ready_o.
module axis_reg_slice #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    assign s_ready_o = (cnt_q != 2'd2);
    assign m_valid_o = (cnt_q != 2'd0);
    assign m_data_o  = head_q;
    assign push      = s_valid_i & s_ready_o;
    assign pop       = m_valid_o & m_ready_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = s_data_i;
                else               tail_d = s_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            // simultaneous push/pop only happens with one entry held
            2'b11: head_d = s_data_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/layer_stream_router.sv
// Routes the DMA stream pair to one of FC/Conv/Pool per APB-started job.
// Define ROUTER_PERF_CNT_EN to build the IN/OUT/STALL performance counters.
module layer_stream_router
    import layer_router_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                                S_AXIS_TLAST,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                                M_AXIS_TLAST,
    output logic                                M_AXIS_TVALID,
    input  logic                                M_AXIS_TREADY,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   L_M_AXIS_TDATA,
    output logic                                L_M_AXIS_TLAST,
    output logic [2:0]                          L_M_AXIS_TVALID,
    input  logic [2:0]                          L_M_AXIS_TREADY,
    input  logic [3*C_S00_AXIS_TDATA_WIDTH-1:0] L_S_AXIS_TDATA,
    input  logic [2:0]                          L_S_AXIS_TLAST,
    input  logic [2:0]                          L_S_AXIS_TVALID,
    output logic [2:0]                          L_S_AXIS_TREADY,
    input  logic [31:0]                         PADDR,
    input  logic                                PSEL,
    input  logic                                PENABLE,
    input  logic                                PWRITE,
    input  logic [31:0]                         PWDATA,
    output logic [31:0]                         PRDATA,
    output logic                                PREADY,
    output logic                                PSLVERR
);

    localparam int W = C_S00_AXIS_TDATA_WIDTH;

    state_e      state_q, state_d;
    logic [1:0]  sel_q;
    logic        in_done_q, done_q, err_q;
    logic        busy, fwd_open, ret_open;
    logic        s_hs, m_hs, out_last_hs;

    logic        fwd_s_ready, fwd_m_valid, fwd_m_ready;
    logic [W:0]  fwd_m_data;
    logic        ret_s_ready, ret_s_valid;
    logic [W:0]  ret_m_data;
    logic [W-1:0] ls_data;
    logic        ls_last, ls_valid;

    logic        apb_acc, apb_wr, apb_rd;
    logic        is_ctrl, is_status, is_perf;
    logic        start_req, start_ok, wr_err, rd_err;
    logic [31:0] perf_rdata;
    logic        unused_pwdata;

    assign busy     = (state_q != IDLE);
    assign fwd_open = (state_q == RUN) & ~in_done_q;
    assign ret_open = (state_q == RUN);

    // ---------------- forward path: DMA -> selected layer
    assign S_AXIS_TREADY = fwd_s_ready & fwd_open;
    assign s_hs          = S_AXIS_TVALID & S_AXIS_TREADY;
    assign fwd_m_ready   = |(L_M_AXIS_TREADY & sel_onehot(sel_q));

    axis_reg_slice #(.WIDTH(W + 1)) u_fwd (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .s_data_i  ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .s_valid_i (S_AXIS_TVALID & fwd_open),
        .s_ready_o (fwd_s_ready),
        .m_data_o  (fwd_m_data),
        .m_valid_o (fwd_m_valid),
        .m_ready_i (fwd_m_ready)
    );

    assign {L_M_AXIS_TLAST, L_M_AXIS_TDATA} = fwd_m_data;
    assign L_M_AXIS_TVALID = {3{fwd_m_valid}} & sel_onehot(sel_q);

    // ---------------- return path: selected layer -> DMA
    always_comb begin
        ls_data  = '0;
        ls_last  = 1'b0;
        ls_valid = 1'b0;
        case (sel_q)
            SEL_FC:   begin ls_data = L_S_AXIS_TDATA[0*W +: W]; ls_last = L_S_AXIS_TLAST[0]; ls_valid = L_S_AXIS_TVALID[0]; end
            SEL_CONV: begin ls_data = L_S_AXIS_TDATA[1*W +: W]; ls_last = L_S_AXIS_TLAST[1]; ls_valid = L_S_AXIS_TVALID[1]; end
            SEL_POOL: begin ls_data = L_S_AXIS_TDATA[2*W +: W]; ls_last = L_S_AXIS_TLAST[2]; ls_valid = L_S_AXIS_TVALID[2]; end
            default: ;
        endcase
    end

    assign ret_s_valid     = ls_valid & ret_open;
    assign L_S_AXIS_TREADY = {3{ret_s_ready & ret_open}} & sel_onehot(sel_q);

    axis_reg_slice #(.WIDTH(W + 1)) u_ret (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .s_data_i  ({ls_last, ls_data}),
        .s_valid_i (ret_s_valid),
        .s_ready_o (ret_s_ready),
        .m_data_o  (ret_m_data),
        .m_valid_o (M_AXIS_TVALID),
        .m_ready_i (M_AXIS_TREADY)
    );

    assign {M_AXIS_TLAST, M_AXIS_TDATA} = ret_m_data;
    assign m_hs        = M_AXIS_TVALID & M_AXIS_TREADY;
    assign out_last_hs = (state_q == RUN) & m_hs & M_AXIS_TLAST;

    // ---------------- APB decode (zero wait states)
    assign apb_acc   = PSEL & PENABLE;
    assign apb_wr    = apb_acc & PWRITE;
    assign apb_rd    = apb_acc & ~PWRITE;
    assign is_ctrl   = (PADDR == ADDR_CTRL);
    assign is_status = (PADDR == ADDR_STATUS);
    assign is_perf   = (PADDR == ADDR_IN_CNT) | (PADDR == ADDR_OUT_CNT) | (PADDR == ADDR_STALL_CNT);
    assign start_req = apb_wr & is_ctrl & PWDATA[CTRL_START_BIT];
    assign start_ok  = start_req & ~busy & (PWDATA[1:0] != SEL_ILLEGAL);
    assign wr_err    = apb_wr & (~is_ctrl | (start_req & (busy | (PWDATA[1:0] == SEL_ILLEGAL))));
    assign rd_err    = apb_rd & ~(is_ctrl | is_status | is_perf);
    assign PSLVERR   = wr_err | rd_err;
    assign PREADY    = 1'b1;
    assign unused_pwdata = ^{PWDATA[31:5], PWDATA[3:2]};

    always_comb begin
        PRDATA = '0;
        if (apb_rd) begin
            if (is_ctrl) begin
                PRDATA[1:0] = sel_q;
            end else if (is_status) begin
                PRDATA[STATUS_BUSY] = busy;
                PRDATA[STATUS_ERR]  = err_q;
                PRDATA[STATUS_DONE] = done_q;
            end else if (is_perf) begin
                PRDATA = perf_rdata;
            end
        end
    end

    // ---------------- job FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (out_last_hs) state_d = DONE_ST;
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sel_q     <= SEL_FC;
            in_done_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                sel_q     <= PWDATA[1:0];
                in_done_q <= 1'b0;
                done_q    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                if (s_hs & S_AXIS_TLAST) in_done_q <= 1'b1;
                if (out_last_hs)         done_q    <= 1'b1;
                if (wr_err)              err_q     <= 1'b1;
            end
        end
    end

`ifdef ROUTER_PERF_CNT_EN
    logic [31:0] in_cnt_q, out_cnt_q, stall_cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (start_ok) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (s_hs)                            in_cnt_q    <= in_cnt_q + 32'd1;
            if (m_hs)                            out_cnt_q   <= out_cnt_q + 32'd1;
            if (M_AXIS_TVALID & ~M_AXIS_TREADY)  stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    always_comb begin
        perf_rdata = '0;
        if (PADDR == ADDR_IN_CNT)         perf_rdata = in_cnt_q;
        else if (PADDR == ADDR_OUT_CNT)   perf_rdata = out_cnt_q;
        else if (PADDR == ADDR_STALL_CNT) perf_rdata = stall_cnt_q;
    end
`else
    assign perf_rdata = '0;
`endif

endmodule

// File: tb/tb_layer_stream_router.sv
// Scoreboard bench for layer_stream_router: forward and return beats are
// queued when driven and checked when they appear at the far side.
module tb_layer_stream_router;

    localparam int W = 32;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [W-1:0]   S_AXIS_TDATA;
    logic           S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TREADY;
    logic [W-1:0]   M_AXIS_TDATA;
    logic           M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY;
    logic [W-1:0]   L_M_AXIS_TDATA;
    logic           L_M_AXIS_TLAST;
    logic [2:0]     L_M_AXIS_TVALID, L_M_AXIS_TREADY;
    logic [3*W-1:0] L_S_AXIS_TDATA;
    logic [2:0]     L_S_AXIS_TLAST, L_S_AXIS_TVALID, L_S_AXIS_TREADY;
    logic [31:0]    PADDR, PWDATA, PRDATA;
    logic           PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    layer_stream_router #(.C_S00_AXIS_TDATA_WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .L_M_AXIS_TDATA(L_M_AXIS_TDATA), .L_M_AXIS_TLAST(L_M_AXIS_TLAST),
        .L_M_AXIS_TVALID(L_M_AXIS_TVALID), .L_M_AXIS_TREADY(L_M_AXIS_TREADY),
        .L_S_AXIS_TDATA(L_S_AXIS_TDATA), .L_S_AXIS_TLAST(L_S_AXIS_TLAST),
        .L_S_AXIS_TVALID(L_S_AXIS_TVALID), .L_S_AXIS_TREADY(L_S_AXIS_TREADY),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 CLK = ~CLK;

    int          checks = 0, failures = 0;
    logic [32:0] fwd_q[$], ret_q[$];
    logic [1:0]  sel_exp = 2'd0;
    bit          sb_en = 1'b1, m_rand = 1'b0;
    int          cyc = 0, stall_exp = 0;
    int          s_first, s_last, lm_first, lm_last, ls_first, m_first, m_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
        #1;
        if (m_rand) M_AXIS_TREADY = 1'($urandom_range(0, 1));
    end

    // monitors sample mid-cycle; a valid&ready seen here completes at the next edge
    always @(negedge CLK) begin
        logic [32:0] e;
        logic [2:0]  oh;
        if (!RESET) begin
            oh = 3'b001 << sel_exp;
            if (|(L_M_AXIS_TVALID & ~oh)) chk("lm_tvalid_onehot", L_M_AXIS_TVALID, oh & L_M_AXIS_TVALID);
            if (|(L_S_AXIS_TREADY & ~oh)) chk("ls_tready_onehot", L_S_AXIS_TREADY, oh & L_S_AXIS_TREADY);
            if (M_AXIS_TVALID && !M_AXIS_TREADY) stall_exp++;
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                if (s_first < 0) s_first = cyc;
                s_last = cyc;
            end
            if (|(L_S_AXIS_TVALID & L_S_AXIS_TREADY & oh)) begin
                if (ls_first < 0) ls_first = cyc;
            end
            if (|(L_M_AXIS_TVALID & L_M_AXIS_TREADY & oh)) begin
                if (lm_first < 0) lm_first = cyc;
                lm_last = cyc;
                if (sb_en) begin
                    if (fwd_q.size() == 0) chk("fwd_unexpected_beat", 1, 0);
                    else begin
                        e = fwd_q.pop_front();
                        chk("fwd_beat", {L_M_AXIS_TLAST, L_M_AXIS_TDATA}, e);
                    end
                end
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (m_first < 0) m_first = cyc;
                m_last = cyc;
                if (sb_en) begin
                    if (ret_q.size() == 0) chk("ret_unexpected_beat", 1, 0);
                    else begin
                        e = ret_q.pop_front();
                        chk("ret_beat", {M_AXIS_TLAST, M_AXIS_TDATA}, e);
                    end
                end
            end
        end
    end

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
        PSEL = 1; PWRITE = 1; PADDR = a; PWDATA = d; PENABLE = 0;
        @(posedge CLK); #1;
        PENABLE = 1;
        @(negedge CLK);
        err = PSLVERR;
        @(posedge CLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
        PSEL = 1; PWRITE = 0; PADDR = a; PENABLE = 0;
        @(posedge CLK); #1;
        PENABLE = 1;
        @(negedge CLK);
        d = PRDATA; err = PSLVERR;
        @(posedge CLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic s_send(input int n, input logic [31:0] base);
        bit ok;
        for (int i = 0; i < n; i++) begin
            S_AXIS_TDATA = base + 32'(i); S_AXIS_TLAST = (i == n - 1); S_AXIS_TVALID = 1;
            ok = 0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge CLK);
                ok = S_AXIS_TREADY;
            end
            if (!ok) begin
                chk("s_send_timeout", 0, 1);
                break;
            end
            fwd_q.push_back({S_AXIS_TLAST, S_AXIS_TDATA});
            @(posedge CLK); #1;
        end
        S_AXIS_TVALID = 0; S_AXIS_TLAST = 0;
    endtask

    task automatic l_send(input int sel, input int n, input logic [31:0] base);
        bit ok;
        for (int i = 0; i < n; i++) begin
            L_S_AXIS_TDATA[sel*W +: W] = base + 32'(i);
            L_S_AXIS_TLAST[sel] = (i == n - 1);
            L_S_AXIS_TVALID[sel] = 1;
            ok = 0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge CLK);
                ok = L_S_AXIS_TREADY[sel];
            end
            if (!ok) begin
                chk("l_send_timeout", 0, 1);
                break;
            end
            ret_q.push_back({L_S_AXIS_TLAST[sel], L_S_AXIS_TDATA[sel*W +: W]});
            @(posedge CLK); #1;
        end
        L_S_AXIS_TVALID[sel] = 0; L_S_AXIS_TLAST[sel] = 0;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        logic e;
        st = 32'h1;
        for (int i = 0; i < 200 && st[0]; i++) apb_rd(32'h04, st, e);
        chk("wait_idle_busy", st[0], 0);
    endtask

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_ctl"}, {S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, L_M_AXIS_TVALID,
                            L_M_AXIS_TLAST, L_S_AXIS_TREADY, PSLVERR}, 0);
        chk({tag, "_data"}, {M_AXIS_TDATA, L_M_AXIS_TDATA}, 0);
        chk({tag, "_prdata"}, PRDATA, 0);
        chk({tag, "_pready"}, PREADY, 1);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] a, input int exp_on);
        logic [31:0] d;
        logic        e;
        apb_rd(a, d, e);
`ifdef ROUTER_PERF_CNT_EN
        chk(tag, d, 32'(exp_on));
`else
        chk(tag, d, 0);
`endif
        chk({tag, "_slverr"}, e, 0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        RESET = 1;
        S_AXIS_TDATA = 0; S_AXIS_TLAST = 0; S_AXIS_TVALID = 0;
        M_AXIS_TREADY = 1; L_M_AXIS_TREADY = 3'b111;
        L_S_AXIS_TDATA = '0; L_S_AXIS_TLAST = 0; L_S_AXIS_TVALID = 0;
        PADDR = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = 0;
        s_first = -1; lm_first = -1; ls_first = -1; m_first = -1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_rst_outs("reset");
        @(posedge CLK); #1;
        RESET = 0;
        apb_rd(32'h04, d, e);
        chk("reset_status", d, 0);
        apb_rd(32'h20, d, e);
        chk("unmapped_rd_data", d, 0);
        chk("unmapped_rd_slverr", e, 1);

        // Conv job: 8 in, 2 out
        apb_wr(32'h00, 32'h11, e);
        chk("t1_start_slverr", e, 0);
        sel_exp = 2'd1;
        apb_rd(32'h04, d, e);
        chk("t1_status_busy", d, 32'h1);
        s_send(8, 32'h1);
        chk("t1_s_tready_after_last", S_AXIS_TREADY, 0);
        repeat (3) @(posedge CLK); #1;
        chk("t1_fwd_drained", fwd_q.size(), 0);
        chk_cnt("t1_in_cnt", 32'h08, 8);
        l_send(1, 2, 32'hA0);
        wait_idle(d);
        chk("t1_status_done", d, 32'h4);
        chk("t1_ret_drained", ret_q.size(), 0);

        // Pool job, 4 result beats under random DMA backpressure
        stall_exp = 0;
        apb_wr(32'h00, 32'h12, e);
        sel_exp = 2'd2;
        m_rand = 1;
        l_send(2, 4, 32'hB0);
        wait_idle(d);
        m_rand = 0; M_AXIS_TREADY = 1;
        chk("t2_status_done", d, 32'h4);
        chk("t2_ret_drained", ret_q.size(), 0);
        chk_cnt("t2_out_cnt", 32'h0C, 4);
        chk_cnt("t2_stall_cnt", 32'h10, stall_exp);
        apb_wr(32'h04, 32'h0, e);
        chk("t2_ro_write_slverr", e, 1);

        // illegal select
        S_AXIS_TVALID = 1; S_AXIS_TDATA = 32'hDEAD;
        apb_wr(32'h00, 32'h13, e);
        chk("t3_sel3_slverr", e, 1);
        apb_rd(32'h04, d, e);
        chk("t3_status_err", d, 32'h6);
        chk("t3_s_tready", S_AXIS_TREADY, 0);
        S_AXIS_TVALID = 0;

        // START while busy; input and output TLAST land on the same edge
        apb_wr(32'h00, 32'h10, e);
        chk("t4_start_slverr", e, 0);
        sel_exp = 2'd0;
        apb_rd(32'h04, d, e);
        chk("t4_status_busy", d, 32'h1);
        apb_wr(32'h00, 32'h12, e);
        chk("t4_busy_start_slverr", e, 1);
        apb_rd(32'h00, d, e);
        chk("t4_sel_unchanged", d, 32'h0);
        apb_rd(32'h04, d, e);
        chk("t4_status_busy_err", d, 32'h3);
        fork
            s_send(4, 32'h40);
            l_send(0, 3, 32'hC0);
        join
        wait_idle(d);
        chk("t4_status_done_err", d, 32'h6);
        repeat (3) @(posedge CLK); #1;
        chk("t4_fwd_drained", fwd_q.size(), 0);

        // reset in the middle of an FC job with both slices full
        apb_wr(32'h00, 32'h10, e);
        sel_exp = 2'd0;
        sb_en = 0;
        L_M_AXIS_TREADY = 3'b000; M_AXIS_TREADY = 0;
        S_AXIS_TVALID = 1; S_AXIS_TDATA = 32'h77;
        L_S_AXIS_TVALID[0] = 1; L_S_AXIS_TDATA[W-1:0] = 32'h88;
        repeat (5) @(posedge CLK); #1;
        chk("t5_pre_m_tvalid", M_AXIS_TVALID, 1);
        RESET = 1;
        #1;
        chk_rst_outs("t5_mid_reset");
        S_AXIS_TVALID = 0; L_S_AXIS_TVALID = 0;
        L_M_AXIS_TREADY = 3'b111; M_AXIS_TREADY = 1;
        @(posedge CLK); #1;
        RESET = 0;
        fwd_q.delete(); ret_q.delete();
        sb_en = 1;
        apb_rd(32'h04, d, e);
        chk("t5_status_after_reset", d, 0);
        apb_wr(32'h00, 32'h10, e);
        fork
            s_send(4, 32'h50);
            l_send(0, 4, 32'hD0);
        join
        wait_idle(d);
        chk("t5_rerun_status", d, 32'h4);
        chk_cnt("t5_rerun_in_cnt", 32'h08, 4);

        // throughput: 64 beats each way, all ready
        apb_wr(32'h00, 32'h11, e);
        sel_exp = 2'd1;
        s_first = -1; lm_first = -1; ls_first = -1; m_first = -1;
        fork
            s_send(64, 32'h1000);
            l_send(1, 64, 32'h2000);
        join
        wait_idle(d);
        chk("t6_status_done", d, 32'h4);
        chk("t6_s_span", s_last - s_first, 63);
        chk("t6_fwd_latency", lm_first - s_first, 1);
        chk("t6_lm_span", lm_last - lm_first, 63);
        chk("t6_ret_latency", m_first - ls_first, 1);
        chk("t6_m_span", m_last - m_first, 63);
        chk("t6_queues_empty", fwd_q.size() + ret_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
